// File: rtl/arduino_sched_pkg.sv
// Shared types and constants for the Arduino code scheduler.
// Optional fixed-priority arbitration is enabled with ARDUINO_SCHED_PRIO_EN.
package arduino_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_HOLD   = 2'd1;
  localparam logic [1:0] ADDR_GAP    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_PRIO_BIT    = 1;
  localparam int CTRL_MASK_LSB    = 8;
  localparam int STATUS_STATE_LSB = 16;
  localparam int STATUS_CODE_LSB  = 24;

  localparam logic [2:0] IDLE_CODE = 3'd0;

  // Link code for a requester index; code 0 stays reserved for idle.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/arduino_rr_arbiter.sv
// Combinational round-robin / fixed-priority pick among pending requesters.
// Fixed priority is only requested by the top when ARDUINO_SCHED_PRIO_EN is set.
module arduino_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [2:0]       rr_ptr,
  input  logic             prio,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_idx,
  output logic             grant_valid
);

  // Scan starting at rr_ptr (or at 0 in priority mode) and take the first set bit.
  always_comb begin
    int  idx;
    logic hit;
    idx         = 0;
    hit         = 1'b0;
    grant_idx   = 3'd0;
    grant_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = prio ? k : int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      hit = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == idx) hit = pending[i];
      end
      if (!grant_valid && hit) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_valid && (grant_idx == 3'(i));
    end
  end

endmodule

// File: rtl/arduino_code_scheduler.sv
// Shares the 3-bit Arduino link between up to 7 detectors: latch, arbitrate, hold, gap.
// Define ARDUINO_SCHED_PRIO_EN to make CTRL.PRIO select fixed lowest-index priority.
module arduino_code_scheduler
  import arduino_sched_pkg::*;
#(
  parameter int               N_REQ    = 4,
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] HOLD_RST = 24'd50000,
  parameter logic [CNT_W-1:0] GAP_RST  = 24'd5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] req_ack,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [2:0]       out_port
);

  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       out_q, out_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             en_q;
  logic [N_REQ-1:0] mask_q;
  logic [CNT_W-1:0] hold_cyc_q, gap_cyc_q;
  logic             prio_eff;
  logic             wr;
  logic [N_REQ-1:0] w1c;
  logic [N_REQ-1:0] grant;
  logic [2:0]       grant_idx;
  logic             grant_valid;
  logic             do_grant;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign w1c          = (wr && address == ADDR_STATUS) ? writedata[N_REQ-1:0] : '0;
  assign unused_wdata = ^writedata;
  assign out_port     = out_q;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      mask_q     <= '1;
      hold_cyc_q <= HOLD_RST;
      gap_cyc_q  <= GAP_RST;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          en_q   <= writedata[CTRL_EN_BIT];
          mask_q <= writedata[CTRL_MASK_LSB +: N_REQ];
        end
        ADDR_HOLD: hold_cyc_q <= writedata[CNT_W-1:0];
        ADDR_GAP:  gap_cyc_q  <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef ARDUINO_SCHED_PRIO_EN
  logic prio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (wr && address == ADDR_CTRL) begin
      prio_q <= writedata[CTRL_PRIO_BIT];
    end
  end

  assign prio_eff = prio_q;
`else
  assign prio_eff = 1'b0;
`endif

  // A fresh detection beats both the grant clear and a W1C in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~req_ack & ~w1c) | (req & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  arduino_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arbiter (
    .pending    (pending_q),
    .rr_ptr     (rr_ptr_q),
    .prio       (prio_eff),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= IDLE_CODE;
      rr_ptr_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Dropping EN abandons the current phase immediately; pending bits survive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        out_d = IDLE_CODE;
        if (do_grant) begin
          out_d   = code_of(grant_idx);
          cnt_d   = at_least_one(hold_cyc_q);
          state_d = HOLD;
          if (!prio_eff) rr_ptr_d = (grant_idx == LAST_IDX) ? 3'd0 : grant_idx + 3'd1;
        end
      end
      HOLD: begin
        if (!en_q) begin
          out_d   = IDLE_CODE;
          state_d = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          out_d   = IDLE_CODE;
          cnt_d   = at_least_one(gap_cyc_q);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        out_d = IDLE_CODE;
        if (!en_q || cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        out_d   = IDLE_CODE;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    do_grant = (state_q == IDLE) && en_q && grant_valid;
    req_ack  = do_grant ? grant : '0;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN_BIT]               = en_q;
        readdata[CTRL_PRIO_BIT]             = prio_eff;
        readdata[CTRL_MASK_LSB +: N_REQ]    = mask_q;
      end
      ADDR_HOLD: readdata[CNT_W-1:0] = hold_cyc_q;
      ADDR_GAP:  readdata[CNT_W-1:0] = gap_cyc_q;
      default: begin
        readdata[N_REQ-1:0]             = pending_q;
        readdata[STATUS_STATE_LSB +: 2] = state_q;
        readdata[STATUS_CODE_LSB +: 3]  = out_q;
      end
    endcase
  end

endmodule

// File: tb/tb_arduino_code_scheduler.sv
// Self-checking bench: directed steps plus random traffic against a timeline model.
// Honours ARDUINO_SCHED_PRIO_EN in the same way as the design.
module tb_arduino_code_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_ack;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [2:0]    out_port;

  int n_pass = 0;
  int n_checks = 0;

  // Model: registers plus a timeline of absolute cycle numbers for the link.
  int           m_cyc = 0;
  int           m_en, m_prio, m_mask, m_hold, m_gap, m_rr, m_code;
  int           m_start, m_end, m_free;
  logic [N-1:0] m_pend;

  arduino_code_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_ack   (req_ack),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, m_cyc, observed, expected);
  endtask

  task automatic modelReset();
    m_en = 0; m_prio = 0; m_mask = 15; m_hold = 50000; m_gap = 5000;
    m_rr = 0; m_code = 0; m_start = 0; m_end = -1; m_free = 0;
    m_pend = '0;
  endtask

  function automatic int modelPick();
    int idx;
    if (m_cyc < m_free || m_en == 0 || m_pend == '0) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_prio != 0) ? k : (m_rr + k) % N;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int modelOut();
    return (m_cyc >= m_start && m_cyc <= m_end) ? m_code : 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    int st;
    st = (m_cyc >= m_start && m_cyc <= m_end) ? 1 : ((m_cyc < m_free) ? 2 : 0);
    case (a)
      2'd0:    return 32'(m_en) | (32'(m_prio) << 1) | (32'(m_mask) << 8);
      2'd1:    return 32'(m_hold);
      2'd2:    return 32'(m_gap);
      default: return 32'(m_pend) | (32'(st) << 16) | (32'(modelOut()) << 24);
    endcase
  endfunction

  task automatic modelAdvance(input int w, input logic [N-1:0] r, input logic wr,
                              input logic [1:0] a, input logic [31:0] d);
    if (m_cyc < m_free && m_en == 0) begin
      if (m_end > m_cyc) m_end = m_cyc;
      m_free = m_cyc + 1;
    end else if (m_cyc < m_free && m_cyc == m_end) begin
      m_free = m_cyc + 1 + ((m_gap == 0) ? 1 : m_gap);
    end
    if (w >= 0) begin
      m_pend[w] = 1'b0;
      if (m_prio == 0) m_rr = (w + 1) % N;
      m_code  = w + 1;
      m_start = m_cyc + 1;
      m_end   = m_cyc + ((m_hold == 0) ? 1 : m_hold);
      m_free  = m_end + 2;
    end
    if (wr && a == 2'd3) m_pend = m_pend & ~d[N-1:0];
    m_pend = m_pend | (r & N'(m_mask));
    if (wr) begin
      case (a)
        2'd0: begin
          m_en   = int'(d[0]);
`ifdef ARDUINO_SCHED_PRIO_EN
          m_prio = int'(d[1]);
`endif
          m_mask = int'(d[8 +: N]);
        end
        2'd1: m_hold = int'(d[23:0]);
        2'd2: m_gap  = int'(d[23:0]);
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, then advance.
  task automatic applyStimulus(input logic [N-1:0] r, input logic wr,
                               input logic [1:0] a, input logic [31:0] d);
    int w;
    logic [N-1:0] ack;
    req = r; chipselect = wr; write_n = !wr; address = a; writedata = d;
    #1;
    w   = modelPick();
    ack = '0;
    if (w >= 0) ack[w] = 1'b1;
    checkOutput("req_ack", 32'(req_ack), 32'(ack));
    checkOutput("out_port", 32'(out_port), 32'(modelOut()));
    checkOutput("readdata", readdata, modelRead(a));
    modelAdvance(w, r, wr, a, d);
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus('0, 1'b1, a, d);
  endtask

  task automatic idleCycles(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, a, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1; req = '0; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk); m_cyc++;
    @(negedge clk); m_cyc++;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [31:0] d;
    logic [N-1:0] r;
    int sel;
    modelReset();
    @(negedge clk);
    doReset();
    for (int a = 0; a < 4; a++) applyStimulus('0, 1'b0, 2'(a), 32'h0);

    $display("[TB] single request, hold 3 gap 2");
    writeReg(2'd0, 32'h0F01); writeReg(2'd1, 32'd3); writeReg(2'd2, 32'd2);
    applyStimulus(4'b0100, 1'b0, 2'd3, 32'h0);
    idleCycles(9, 2'd3);

    $display("[TB] three simultaneous requests from rr_ptr 0");
    doReset();
    writeReg(2'd0, 32'h0F01); writeReg(2'd1, 32'd2); writeReg(2'd2, 32'd1);
    applyStimulus(4'b1011, 1'b0, 2'd3, 32'h0);
    idleCycles(16, 2'd3);

    $display("[TB] mask and W1C versus set");
    writeReg(2'd0, 32'h0E01);
    applyStimulus(4'b0001, 1'b0, 2'd3, 32'h0);
    idleCycles(3, 2'd3);
    writeReg(2'd0, 32'h0E00);
    applyStimulus(4'b0010, 1'b1, 2'd3, 32'h2);
    idleCycles(2, 2'd3);
    writeReg(2'd3, 32'h2);
    idleCycles(1, 2'd3);

    $display("[TB] EN cleared mid-hold");
    writeReg(2'd0, 32'h0F01); writeReg(2'd1, 32'd5);
    applyStimulus(4'b0101, 1'b0, 2'd3, 32'h0);
    idleCycles(2, 2'd3);
    writeReg(2'd0, 32'h0F00);
    idleCycles(3, 2'd3);
    writeReg(2'd0, 32'h0F01);
    idleCycles(14, 2'd3);

    $display("[TB] zero hold and gap, then reset during hold");
    writeReg(2'd1, 32'd0); writeReg(2'd2, 32'd0);
    applyStimulus(4'b0011, 1'b0, 2'd3, 32'h0);
    idleCycles(6, 2'd3);
    writeReg(2'd1, 32'd4);
    applyStimulus(4'b0010, 1'b0, 2'd3, 32'h0);
    idleCycles(2, 2'd3);
    doReset();
    for (int a = 0; a < 4; a++) applyStimulus('0, 1'b0, 2'(a), 32'h0);

    $display("[TB] PRIO bit");
    writeReg(2'd0, 32'h0F03); writeReg(2'd1, 32'd1); writeReg(2'd2, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, 1'b0, 2'd3, 32'h0);
      idleCycles(6, 2'd0);
    end

    $display("[TB] random traffic");
    writeReg(2'd0, 32'h0F01);
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 15));
      r   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      case (sel)
        0: begin
          d = {20'h0, 4'($urandom), 6'h0, 1'($urandom), 1'($urandom_range(0, 3) != 0)};
          applyStimulus(r, 1'b1, 2'd0, d);
        end
        1: applyStimulus(r, 1'b1, 2'd1, 32'($urandom_range(0, 3)));
        2: applyStimulus(r, 1'b1, 2'd2, 32'($urandom_range(0, 3)));
        3: applyStimulus(r, 1'b1, 2'd3, 32'($urandom_range(0, 15)));
        default: applyStimulus(r, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
